// File: rtl/dmem_ctrl_pkg.sv
// Shared types and constants for the data-memory access controller.
// Byte-lane helper is used to serialise a 32-bit store into little-endian beats.
package dmem_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } state_e;

   localparam int BEATS_WORD = 4;
   localparam int BEATS_BYTE = 1;
   localparam int BYTE_W     = 8;
   localparam int PORT_LSU   = 0;
   localparam int PORT_DBG   = 1;

   function automatic logic [BYTE_W-1:0] get_byte(input logic [31:0] w, input logic [1:0] idx);
      logic [BYTE_W-1:0] b;
      case (idx)
         2'd0:    b = w[7:0];
         2'd1:    b = w[15:8];
         2'd2:    b = w[23:16];
         default: b = w[31:24];
      endcase
      return b;
   endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; the caller owns and updates last_grant.
// On a tie the port that did not win last time is chosen.
module rr_arb2 (
   input  logic [1:0] req_i,
   input  logic       last_grant_i,
   output logic       gnt_valid_o,
   output logic       gnt_idx_o
);

   assign gnt_valid_o = |req_i;
   assign gnt_idx_o   = (req_i == 2'b11) ? ~last_grant_i : req_i[1];

endmodule

// File: rtl/dmem_access_ctrl.sv
// Arbitrates the LSU and debug ports onto a byte-wide single-cycle data memory,
// splitting word accesses into four little-endian byte beats.
module dmem_access_ctrl
   import dmem_ctrl_pkg::*;
#(
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [1:0]        req,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [1:0]        we,
   input  logic [1:0]        word,
   input  logic [31:0]       wdata0,
   input  logic [31:0]       wdata1,
   output logic [1:0]        done,
   output logic [31:0]       rdata,
   output logic              busy,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [7:0]        mem_wdata,
   input  logic [7:0]        mem_rdata
);

   state_e            state_q;
   logic [1:0]        beat_q;
   logic              lastGrant_q;
   logic              owner_q;
   logic [ADDR_W-1:0] base_q;
   logic              we_q;
   logic              word_q;
   logic [31:0]       wdata_q;
   logic [31:0]       rbuf_q;
   logic [31:0]       rdata_q;

   logic              gntValid;
   logic              gntIdx;
   logic [1:0]        lastBeat;
   logic [31:0]       rbuf_d;

   rr_arb2 u_arb (
      .req_i        (req),
      .last_grant_i (lastGrant_q),
      .gnt_valid_o  (gntValid),
      .gnt_idx_o    (gntIdx)
   );

   assign lastBeat = word_q ? 2'(BEATS_WORD - 1) : 2'(BEATS_BYTE - 1);

   // Read buffer with the current beat's byte merged in, so the final beat can
   // update rdata on the same edge it is captured. The buffer is cleared at
   // grant, which makes a byte load come out zero-extended for free.
   always_comb begin
      rbuf_d = rbuf_q;
      case (beat_q)
         2'd0:    rbuf_d[7:0]   = mem_rdata;
         2'd1:    rbuf_d[15:8]  = mem_rdata;
         2'd2:    rbuf_d[23:16] = mem_rdata;
         default: rbuf_d[31:24] = mem_rdata;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         beat_q      <= '0;
         lastGrant_q <= 1'b1;
         owner_q     <= 1'b0;
         base_q      <= '0;
         we_q        <= 1'b0;
         word_q      <= 1'b0;
         wdata_q     <= '0;
         rbuf_q      <= '0;
         rdata_q     <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (gntValid) begin
                  owner_q <= gntIdx;
                  base_q  <= (gntIdx == 1'(PORT_DBG)) ? addr1 : addr0;
                  wdata_q <= (gntIdx == 1'(PORT_DBG)) ? wdata1 : wdata0;
                  we_q    <= we[gntIdx];
                  word_q  <= word[gntIdx];
                  beat_q  <= '0;
                  rbuf_q  <= '0;
                  state_q <= ACCESS;
               end
            end
            ACCESS: begin
               if (!we_q) begin
                  rbuf_q <= rbuf_d;
               end
               if (beat_q == lastBeat) begin
                  if (!we_q) begin
                     rdata_q <= rbuf_d;
                  end
                  state_q <= DONE;
               end else begin
                  beat_q <= beat_q + 2'd1;
               end
            end
            DONE: begin
               lastGrant_q <= owner_q;
               state_q     <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   always_comb begin
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      done      = '0;
      if (state_q == ACCESS) begin
         mem_en    = 1'b1;
         mem_we    = we_q;
         mem_addr  = base_q + ADDR_W'(beat_q);
         mem_wdata = get_byte(wdata_q, beat_q);
      end
      if (state_q == DONE) begin
         done[owner_q] = 1'b1;
      end
   end

   assign busy  = (state_q != IDLE);
   assign rdata = rdata_q;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Scoreboard bench for dmem_access_ctrl: expected beats and completions are queued
// when a request is driven and compared as the controller produces them.
module tb_dmem_access_ctrl;

   localparam int ADDR_W = 32;

   typedef struct {
      int          port;
      logic [31:0] rdata;
      int          cyc;
   } txn_t;

   typedef struct {
      logic [31:0] addr;
      logic        we;
      logic [7:0]  wdata;
   } beat_t;

   logic              clk = 1'b0;
   logic              reset;
   logic [1:0]        req;
   logic [ADDR_W-1:0] addr0, addr1;
   logic [1:0]        we, word;
   logic [31:0]       wdata0, wdata1;
   logic [1:0]        done;
   logic [31:0]       rdata;
   logic              busy;
   logic              mem_en, mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [7:0]        mem_wdata, mem_rdata;

   logic [7:0]  mem [0:63];
   txn_t        txnQ[$];
   beat_t       beatQ[$];
   int          cyc = 0;
   int          compared = 0;
   int          mismatched = 0;
   logic [31:0] modelRdata = 32'h0;

   dmem_access_ctrl #(.ADDR_W(ADDR_W)) dut (
      .clk       (clk),
      .reset     (reset),
      .req       (req),
      .addr0     (addr0),
      .addr1     (addr1),
      .we        (we),
      .word      (word),
      .wdata0    (wdata0),
      .wdata1    (wdata1),
      .done      (done),
      .rdata     (rdata),
      .busy      (busy),
      .mem_en    (mem_en),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata)
   );

   always #5 clk = ~clk;

   // Small memory aliased on the low 6 address bits; 0xFFFFFFFE/F land on 62/63.
   assign mem_rdata = mem[mem_addr[5:0]];
   always @(posedge clk) begin
      if (mem_en && mem_we) mem[mem_addr[5:0]] <= mem_wdata;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string tag, input logic [63:0] act, input logic [63:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   task automatic pushBeats(input logic [31:0] addr, input logic isWe, input logic [31:0] wdata, input int n);
      for (int i = 0; i < n; i++) begin
         logic [31:0] a;
         a = addr + 32'(i);
         beatQ.push_back('{a, isWe, wdata[8*i +: 8]});
      end
   endtask

   task automatic pushTxn(input int port, input logic [31:0] addr, input logic isWe, input logic isWord,
                          input logic [31:0] wdata, input logic [31:0] loadVal, input int expCyc);
      pushBeats(addr, isWe, wdata, isWord ? 4 : 1);
      if (!isWe) modelRdata = isWord ? loadVal : {24'h0, loadVal[7:0]};
      txnQ.push_back('{port, modelRdata, expCyc});
   endtask

   task automatic applyStimulus(input int port, input logic [31:0] addr, input logic isWe,
                                input logic isWord, input logic [31:0] wdata);
      if (port == 0) begin
         addr0 = addr; wdata0 = wdata;
      end else begin
         addr1 = addr; wdata1 = wdata;
      end
      we[port]   = isWe;
      word[port] = isWord;
      req[port]  = 1'b1;
   endtask

   task automatic waitDone(input int port);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!done[port] && n < 30);
      if (!done[port]) checkOutput("done timeout", 64'(done), 64'(2'b01 << port));
      req[port] = 1'b0;
      @(negedge clk);
   endtask

   task automatic runTxn(input int port, input logic [31:0] addr, input logic isWe, input logic isWord,
                         input logic [31:0] wdata, input logic [31:0] loadVal);
      applyStimulus(port, addr, isWe, isWord, wdata);
      pushTxn(port, addr, isWe, isWord, wdata, loadVal, cyc + (isWord ? 5 : 2));
      waitDone(port);
   endtask

   // Scoreboard monitor, sampled on the falling edge away from state updates.
   always @(negedge clk) begin
      beat_t b;
      txn_t  t;
      if (!reset) begin
         if (mem_en) begin
            if (beatQ.size() == 0) begin
               checkOutput("unexpected beat", 64'(mem_addr), 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
               b = beatQ.pop_front();
               checkOutput("beat addr", 64'(mem_addr), 64'(b.addr));
               checkOutput("beat we", 64'(mem_we), 64'(b.we));
               checkOutput("beat wdata", 64'(mem_wdata), 64'(b.wdata));
            end
         end
         if (done != 2'b00) begin
            if (txnQ.size() == 0) begin
               checkOutput("unexpected done", 64'(done), 64'h0);
            end else begin
               t = txnQ.pop_front();
               checkOutput("done port", 64'(done), 64'(2'b01 << t.port));
               checkOutput("rdata", 64'(rdata), 64'(t.rdata));
               if (t.cyc >= 0) checkOutput("done cycle", 64'(cyc), 64'(t.cyc));
            end
         end
      end
   end

   initial begin
      int k;
      int count;
      int n;

      reset = 1'b1;
      req = 2'b00; we = 2'b00; word = 2'b00;
      addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
      repeat (2) @(negedge clk);
      checkOutput("reset done", 64'(done), 64'h0);
      checkOutput("reset rdata", 64'(rdata), 64'h0);
      checkOutput("reset busy", 64'(busy), 64'h0);
      checkOutput("reset mem_en", 64'(mem_en), 64'h0);
      checkOutput("reset mem_we", 64'(mem_we), 64'h0);
      checkOutput("reset mem_addr", 64'(mem_addr), 64'h0);
      checkOutput("reset mem_wdata", 64'(mem_wdata), 64'h0);
      reset = 1'b0;
      @(negedge clk);

      $display("[TB] preload through the debug port");
      runTxn(1, 32'd5, 1'b1, 1'b0, 32'h0000_00A7, 32'h0);
      runTxn(1, 32'd8, 1'b1, 1'b1, 32'hDEAD_BEEF, 32'h0);
      runTxn(1, 32'd20, 1'b1, 1'b0, 32'h0000_005A, 32'h0);
      runTxn(1, 32'd30, 1'b1, 1'b0, 32'h0000_00C3, 32'h0);
      runTxn(1, 32'hFFFF_FFFE, 1'b1, 1'b1, 32'h4433_2211, 32'h0);
      checkOutput("mem[8]", 64'(mem[8]), 64'hEF);
      checkOutput("mem[11]", 64'(mem[11]), 64'hDE);
      checkOutput("mem wrap [0]", 64'(mem[0]), 64'h33);

      $display("[TB] loads");
      runTxn(0, 32'd5, 1'b0, 1'b0, 32'h0, 32'h0000_00A7);

      // Attribute hold: change addr0/we0/word0 once the beats have started.
      applyStimulus(0, 32'd8, 1'b0, 1'b1, 32'h1234_5678);
      pushTxn(0, 32'd8, 1'b0, 1'b1, 32'h1234_5678, 32'hDEAD_BEEF, cyc + 5);
      @(negedge clk);
      checkOutput("busy in access", 64'(busy), 64'h1);
      addr0 = 32'd40; we[0] = 1'b1; word[0] = 1'b0;
      waitDone(0);

      runTxn(1, 32'd8, 1'b0, 1'b1, 32'h0, 32'hDEAD_BEEF);
      runTxn(0, 32'hFFFF_FFFE, 1'b0, 1'b1, 32'h0, 32'h4433_2211);
      runTxn(1, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0, 32'h0000_0022);
      runTxn(0, 32'd12, 1'b1, 1'b0, 32'h0000_0099, 32'h0);
      checkOutput("mem[12]", 64'(mem[12]), 64'h99);

      $display("[TB] reset during beat 2 of a word store");
      runTxn(1, 32'd0, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'h0);
      applyStimulus(0, 32'd0, 1'b1, 1'b1, 32'h0102_0304);
      pushBeats(32'd0, 1'b1, 32'h0102_0304, 3);
      repeat (3) @(negedge clk);
      #1 reset = 1'b1;
      req = 2'b00;
      #1;
      checkOutput("abort mem_en", 64'(mem_en), 64'h0);
      checkOutput("abort mem_we", 64'(mem_we), 64'h0);
      checkOutput("abort mem_addr", 64'(mem_addr), 64'h0);
      checkOutput("abort mem_wdata", 64'(mem_wdata), 64'h0);
      checkOutput("abort done", 64'(done), 64'h0);
      checkOutput("abort busy", 64'(busy), 64'h0);
      checkOutput("abort rdata", 64'(rdata), 64'h0);
      modelRdata = 32'h0;
      @(negedge clk);
      reset = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("abort mem[0]", 64'(mem[0]), 64'h04);
      checkOutput("abort mem[1]", 64'(mem[1]), 64'h03);
      checkOutput("abort mem[2]", 64'(mem[2]), 64'hFF);
      checkOutput("abort mem[3]", 64'(mem[3]), 64'hFF);

      $display("[TB] contention, both ports requesting byte loads");
      addr0 = 32'd20; we[0] = 1'b0; word[0] = 1'b0; wdata0 = '0;
      addr1 = 32'd30; we[1] = 1'b0; word[1] = 1'b0; wdata1 = '0;
      k = cyc;
      req = 2'b11;
      for (int i = 0; i < 4; i++) begin
         int p;
         p = i % 2;
         pushTxn(p, (p == 0) ? 32'd20 : 32'd30, 1'b0, 1'b0, 32'h0,
                 (p == 0) ? 32'h5A : 32'hC3, k + 2 + 3 * i);
      end
      count = 0;
      n = 0;
      while (count < 4 && n < 60) begin
         @(negedge clk);
         n++;
         if (done != 2'b00) count++;
      end
      req = 2'b00;
      if (count < 4) checkOutput("contention timeout", 64'(count), 64'd4);
      repeat (4) @(negedge clk);

      checkOutput("beats left", 64'(beatQ.size()), 64'h0);
      checkOutput("txns left", 64'(txnQ.size()), 64'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/dmem_access_ctrl.md
Name: dmem_access_ctrl

Overview:
- Arbitrates two requesters onto one byte-wide, single-cycle data memory port.
- Sequences each request as byte beats: one beat for a byte access, four beats for a word access, little-endian.
- Port 0 is the MEM-stage load/store unit; port 1 is the debug/loader port used to preload and dump data memory.
- Provides the multi-cycle done handshake the pipeline stalls on.

Parameters:
ADDR_W, 32, byte-address width of requester and memory address buses; address arithmetic wraps modulo 2^ADDR_W.

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
req  in  2  per-port request; must be held stable with its attributes until the matching done pulse
addr0, addr1  in  ADDR_W  per-port byte address
we  in  2  per-port write enable (1 = store, 0 = load)
word  in  2  per-port size (1 = 32-bit word, 0 = byte)
wdata0, wdata1  in  32  per-port store data; byte access uses bits [7:0]
done  out  2  one-cycle per-port completion pulse
rdata  out  32  load result, valid in the done cycle, held until the next done
busy  out  1  high whenever the FSM is not IDLE
mem_en  out  1  memory beat strobe
mem_we  out  1  memory write strobe, qualified by mem_en
mem_addr  out  ADDR_W  memory byte address
mem_wdata  out  8  memory write byte
mem_rdata  in  8  memory read byte, combinational from mem_addr in the same cycle

Behaviour:
- Reset (async, any state):
  - FSM goes to IDLE; beat counter is 0; last_grant is 1, so port 0 wins the first tie.
  - done, rdata, mem_en, mem_we, mem_addr, mem_wdata and busy are all 0.
  - An in-flight transaction is aborted with no done pulse. Bytes already written stay in memory.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - If any req bit is set, pick the winner: a sole requester wins; if both request, the port not equal to last_grant wins.
  - Latch owner, addr, we, word and wdata; clear the beat counter and the read buffer; go to ACCESS.
  - With no request, stay in IDLE.
- ACCESS (one beat per cycle):
  - mem_en = 1, mem_addr = base + beat (mod 2^ADDR_W), mem_we = latched we, mem_wdata = latched wdata[8*beat+7 : 8*beat].
  - On a read beat, capture mem_rdata into read-buffer byte lane [beat] at the clock edge.
  - last beat = 0 for a byte access, 3 for a word access. At the last beat go to DONE; otherwise increment beat.
- DONE:
  - done[owner] = 1 for exactly one cycle; rdata is updated from the read buffer.
  - A byte load returns {24'b0, byte} (zero-extended). A store leaves rdata unchanged.
  - Set last_grant = owner; go to IDLE.
- Memory outputs:
  - mem_* are decoded from registered state only; there is no combinational path from req.
  - mem_en, mem_we, mem_addr and mem_wdata are 0 in IDLE and DONE.
- Latency, with the request first seen in IDLE at cycle T:
  - byte access: beat at T+1, done at T+2;
  - word access: beats at T+1..T+4, done at T+5.
  - Throughput is one transaction per 3 (byte) or 6 (word) cycles.
- Handshake rules:
  - req, addr, we, word and wdata are sampled only in the IDLE grant cycle. Changes after the grant are ignored until done.
  - If req is still high in the cycle after done, it is a new transaction and is arbitrated in that IDLE cycle.
  - A requester that deasserts req mid-transaction does not cancel it; done still pulses.
- Boundaries:
  - Misaligned word addresses are legal: beats are simply sequential bytes.
  - base = 2^ADDR_W - 2 wraps to addresses 0 and 1 for beats 2 and 3.
  - The non-owner port waits with no done. It is granted next if still requesting, which guarantees no starvation.

Decomposition:
- Shared package dmem_ctrl_pkg holds:
  - the state enum (IDLE, ACCESS, DONE);
  - BEATS_WORD = 4 and BEATS_BYTE = 1;
  - BYTE_W = 8;
  - the port index constants PORT_LSU = 0 and PORT_DBG = 1.
- One sub-module, rr_arb2: a 2-way round-robin arbiter.
  - Inputs: req[1:0], last_grant. Outputs: gnt_valid, gnt_idx.
  - Combinational; last_grant is owned by the parent.

Test Plan:
- Byte read: mem[5]=0xA7; port 0 req, addr 5, we 0, word 0 -> one beat at mem_addr 5; done[0] at T+2; rdata 0x000000A7.
- Word write then read: port 1 stores 0xDEADBEEF at addr 8 -> bytes EF, BE, AD, DE written to addresses 8..11; done[1] at T+5. A following word load at 8 returns 0xDEADBEEF.
- Contention: both ports request continuously with byte reads -> grants in the order 0, 1, 0, 1; each done is one-hot, and done never pulses for the non-owner.
- Wrap-around: word read at 0xFFFFFFFE with mem[FFFFFFFE]=11, [FFFFFFFF]=22, [0]=33, [1]=44 -> rdata 0x44332211.
- Reset mid-transaction: assert reset during beat 2 of a word store of 0x01020304 at addr 0 -> all outputs 0 immediately; bytes 04 and 03 remain in memory; no done.
- Attribute hold: change addr0 during ACCESS -> the beats still use the address latched at grant.
